// File: rtl/seq_event_logger.sv
// seq_event_logger: timestamps qualified detector events into a FWFT FIFO
// drained over valid/ready; keeps a saturating event count and sticky overflow.
module seq_event_logger #(
    parameter int TS_W      = 16,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16,
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    det,
    input  logic                    en,
    input  logic                    clr,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [TS_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [CNT_W-1:0]        event_count,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [TS_W-1:0]  ts;
    logic             det_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [TS_W-1:0]  mem [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic sclr;
    logic evt;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign sclr = rst | clr;

    always_comb begin
        evt = en & det;
        if (EDGE_MODE) begin
            evt = en & det & ~det_q;
        end
    end

    assign full = (level == FULL_LVL);
    assign rd_valid = (level != '0);
    assign pop = rd_valid & rd_ready;

    // A full FIFO still accepts an event when the head leaves the same cycle.
    assign push = evt & (~full | pop);
    assign drop = evt & full & ~pop;

    // Gated so the output reads zero after reset, when storage is stale.
    assign rd_data = rd_valid ? mem[rd_ptr] : '0;

    assign fifo_level  = level;
    assign event_count = cnt;
    assign overflow    = ovf;

    always_ff @(posedge clk) begin
        if (sclr) begin
            ts     <= '0;
            det_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            det_q <= det;
            if (en) begin
                ts <= ts + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (evt && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !sclr) begin
            mem[wr_ptr] <= ts;
        end
    end

endmodule

// File: tb/tb_seq_event_logger.sv
// Bench for seq_event_logger: three parameterisations, directed stimulus,
// expected timestamps queued per instance and checked by negedge monitors.
module tb_seq_event_logger;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] det;
    logic [2:0] en;
    logic [2:0] clr;
    logic [2:0] rdy;

    logic        vld0, vld1, vld2;
    logic        ovf0, ovf1, ovf2;
    logic [15:0] d0, d1;
    logic [3:0]  d2;
    logic [3:0]  l0, l1;
    logic [2:0]  l2;
    logic [15:0] c0, c1;
    logic [2:0]  c2;

    int unsigned q0[$];
    int unsigned q1[$];
    int unsigned q2[$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_event_logger #(
        .TS_W(16), .DEPTH(8), .CNT_W(16), .EDGE_MODE(1'b0)
    ) u0 (
        .clk(clk), .rst(rst), .det(det[0]), .en(en[0]), .clr(clr[0]),
        .rd_valid(vld0), .rd_ready(rdy[0]), .rd_data(d0),
        .fifo_level(l0), .event_count(c0), .overflow(ovf0)
    );

    seq_event_logger #(
        .TS_W(16), .DEPTH(8), .CNT_W(16), .EDGE_MODE(1'b1)
    ) u1 (
        .clk(clk), .rst(rst), .det(det[1]), .en(en[1]), .clr(clr[1]),
        .rd_valid(vld1), .rd_ready(rdy[1]), .rd_data(d1),
        .fifo_level(l1), .event_count(c1), .overflow(ovf1)
    );

    seq_event_logger #(
        .TS_W(4), .DEPTH(4), .CNT_W(3), .EDGE_MODE(1'b0)
    ) u2 (
        .clk(clk), .rst(rst), .det(det[2]), .en(en[2]), .clr(clr[2]),
        .rd_valid(vld2), .rd_ready(rdy[2]), .rd_data(d2),
        .fifo_level(l2), .event_count(c2), .overflow(ovf2)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic nopop(input string nm, input longint act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected pop, data %0d, queue empty", nm, act);
    endtask

    // Monitors: every accepted head entry must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && !clr[0] && vld0 && rdy[0]) begin
            if (q0.size() == 0) nopop("pop0", d0);
            else chk("pop0", d0, q0.pop_front());
        end
        if (!rst && !clr[1] && vld1 && rdy[1]) begin
            if (q1.size() == 0) nopop("pop1", d1);
            else chk("pop1", d1, q1.pop_front());
        end
        if (!rst && !clr[2] && vld2 && rdy[2]) begin
            if (q2.size() == 0) nopop("pop2", d2);
            else chk("pop2", d2, q2.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        det = '0;
        en  = '0;
        clr = '0;
        rdy = '0;
        tick(1);
        rst = 1'b0;

        chk("rst vld0", vld0, 0);
        chk("rst data0", d0, 0);
        chk("rst lvl0", l0, 0);
        chk("rst cnt0", c0, 0);
        chk("rst ovf0", ovf0, 0);
        chk("rst vld2", vld2, 0);

        // idle with det low: nothing stored, ts reaches 10
        en[0] = 1'b1;
        tick(10);
        chk("idle lvl", l0, 0);
        chk("idle vld", vld0, 0);
        chk("idle cnt", c0, 0);
        det[0] = 1'b1;
        q0.push_back(10);
        tick(1);
        det[0] = 1'b0;
        chk("ts10 lvl", l0, 1);
        chk("ts10 cnt", c0, 1);
        chk("ts10 head", d0, 10);
        rdy[0] = 1'b1;
        tick(2);
        rdy[0] = 1'b0;
        chk("ts10 drained", l0, 0);

        // level mode: det high at ts 3..5
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        tick(3);
        det[0] = 1'b1;
        q0.push_back(3);
        q0.push_back(4);
        q0.push_back(5);
        tick(3);
        det[0] = 1'b0;
        chk("run3 lvl", l0, 3);
        chk("run3 cnt", c0, 3);
        chk("run3 ovf", ovf0, 0);
        rdy[0] = 1'b1;
        tick(4);
        rdy[0] = 1'b0;
        chk("run3 drained", l0, 0);
        chk("run3 q", q0.size(), 0);

        // empty with evt+ready, then partial with evt+pop
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        det[0] = 1'b1;
        rdy[0] = 1'b1;
        q0.push_back(0);
        tick(1);
        chk("empty evt+rdy lvl", l0, 1);
        q0.push_back(1);
        tick(1);
        chk("partial evt+pop lvl", l0, 1);
        det[0] = 1'b0;
        tick(1);
        rdy[0] = 1'b0;
        chk("partial drained", l0, 0);

        // overflow: 10 single-cycle events at ts 0,2,..,18
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            det[0] = 1'b1;
            if (i < 8) q0.push_back(2 * i);
            tick(1);
            det[0] = 1'b0;
            tick(1);
        end
        chk("ovf lvl", l0, 8);
        chk("ovf flag", ovf0, 1);
        chk("ovf cnt", c0, 10);
        chk("ovf head", d0, 0);
        en[0] = 1'b0;
        rdy[0] = 1'b1;
        tick(9);
        rdy[0] = 1'b0;
        en[0] = 1'b1;
        chk("ovf drained", l0, 0);
        chk("ovf sticky", ovf0, 1);
        chk("ovf q", q0.size(), 0);

        // full FIFO with evt and pop together
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        chk("clr ovf", ovf0, 0);
        det[0] = 1'b1;
        for (int i = 0; i < 8; i++) q0.push_back(i);
        tick(8);
        rdy[0] = 1'b1;
        q0.push_back(8);
        tick(1);
        det[0] = 1'b0;
        rdy[0] = 1'b0;
        chk("full evt+pop lvl", l0, 8);
        chk("full evt+pop ovf", ovf0, 0);
        chk("full evt+pop cnt", c0, 9);
        chk("full evt+pop head", d0, 1);
        en[0] = 1'b0;
        rdy[0] = 1'b1;
        tick(9);
        rdy[0] = 1'b0;
        chk("full drained", l0, 0);
        chk("full q", q0.size(), 0);

        // edge mode: det high for ts 7..12 gives one event
        clr[1] = 1'b1;
        tick(1);
        clr[1] = 1'b0;
        en[1] = 1'b1;
        tick(7);
        det[1] = 1'b1;
        q1.push_back(7);
        tick(6);
        det[1] = 1'b0;
        tick(1);
        chk("edge lvl", l1, 1);
        chk("edge cnt", c1, 1);
        chk("edge head", d1, 7);
        rdy[1] = 1'b1;
        tick(2);
        rdy[1] = 1'b0;
        det[1] = 1'b1;
        q1.push_back(16);
        tick(2);
        det[1] = 1'b0;
        chk("edge2 cnt", c1, 2);
        chk("edge2 lvl", l1, 1);
        rdy[1] = 1'b1;
        tick(2);
        rdy[1] = 1'b0;
        chk("edge q", q1.size(), 0);
        chk("edge ovf", ovf1, 0);

        // 3-bit count saturates while the FIFO streams
        clr[2] = 1'b1;
        tick(1);
        clr[2] = 1'b0;
        en[2] = 1'b1;
        det[2] = 1'b1;
        rdy[2] = 1'b1;
        for (int i = 0; i < 10; i++) q2.push_back(i);
        tick(10);
        det[2] = 1'b0;
        tick(2);
        rdy[2] = 1'b0;
        chk("sat cnt", c2, 7);
        chk("sat lvl", l2, 0);
        chk("sat ovf", ovf2, 0);
        chk("sat q", q2.size(), 0);

        // 4-bit timestamp wraps 15 -> 0
        clr[2] = 1'b1;
        tick(1);
        clr[2] = 1'b0;
        tick(15);
        det[2] = 1'b1;
        q2.push_back(15);
        q2.push_back(0);
        tick(2);
        det[2] = 1'b0;
        chk("wrap lvl", l2, 2);
        chk("wrap head", d2, 15);
        rdy[2] = 1'b1;
        tick(1);
        rdy[2] = 1'b0;
        chk("wrap head2", d2, 0);

        // clear mid-stream discards stored data and the coincident event
        clr[2] = 1'b1;
        det[2] = 1'b1;
        tick(1);
        clr[2] = 1'b0;
        det[2] = 1'b0;
        q2.delete();
        chk("clr vld", vld2, 0);
        chk("clr data", d2, 0);
        chk("clr lvl", l2, 0);
        chk("clr cnt", c2, 0);
        chk("clr ovf", ovf2, 0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
